// File: rtl/range_parser_if.sv
// ---------------------------------------------------------------------------
// range_parser_if
// Groups the byte-stream handshake, the range-FIFO write port and the parser
// status signals of range_parser.
//   master : the parser side (consumes bytes, writes ranges, reports status)
//   slave  : the environment side (byte source, FIFO, status observer)
// Signals:
//   in_valid / in_byte / in_ready   ASCII byte stream handshake
//   wr_en, input_range_low/high,
//   input_range_fresh, fifo_full    range-FIFO write port
//   ranges_done, range_count, err   sticky status and write counter
// ---------------------------------------------------------------------------
interface range_parser_if #(
  parameter int ADDR_W = 17,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic [7:0]        in_byte;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] input_range_low;
  logic [ADDR_W-1:0] input_range_high;
  logic              input_range_fresh;
  logic              fifo_full;
  logic              ranges_done;
  logic [CNT_W-1:0]  range_count;
  logic              err;

  modport master (
    input  in_valid, in_byte, fifo_full,
    output in_ready, wr_en, input_range_low, input_range_high,
           input_range_fresh, ranges_done, range_count, err
  );

  modport slave (
    output in_valid, in_byte, fifo_full,
    input  in_ready, wr_en, input_range_low, input_range_high,
           input_range_fresh, ranges_done, range_count, err
  );
endinterface

// File: rtl/range_parser.sv
// ---------------------------------------------------------------------------
// range_parser
// Parses an ASCII list of "low-high\n" lines into inclusive address ranges
// and writes each one to a range FIFO. A blank line ends the list; any
// malformed input latches a sticky error and drains the rest of the stream.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   range_parser_if.master (byte stream in, FIFO write out, status)
// Parameters:
//   ADDR_W  width of each range bound
//   CNT_W   width of range_count
// ---------------------------------------------------------------------------
module range_parser #(
  parameter int ADDR_W = 17,
  parameter int CNT_W  = 16
) (
  input  logic           clk,
  input  logic           rst,
  range_parser_if.master bus
);

  // Four spare bits let acc*10+digit be formed without wrapping before the
  // overflow comparison.
  localparam int ACC_W = ADDR_W + 4;
  localparam logic [ACC_W-1:0] BOUND_MAX = {{4{1'b0}}, {ADDR_W{1'b1}}};

  typedef enum logic [2:0] {
    LOW,
    HIGH,
    EMIT,
    DONE,
    ERR
  } state_t;

  state_t            state_reg;
  logic [ACC_W-1:0]  acc_low_reg;
  logic [ACC_W-1:0]  acc_high_reg;
  logic              seen_low_reg;
  logic              seen_high_reg;
  logic [ADDR_W-1:0] low_reg;
  logic [ADDR_W-1:0] high_reg;
  logic [CNT_W-1:0]  count_reg;

  logic             is_digit;
  logic             is_dash;
  logic             is_lf;
  logic             is_cr;
  logic [ACC_W-1:0] digit_ext;
  logic [ACC_W-1:0] acc_low_next;
  logic [ACC_W-1:0] acc_high_next;
  logic             consume;
  logic             in_ready_int;
  logic             wr_en_int;

  always_comb begin
    is_digit      = (bus.in_byte >= 8'h30) && (bus.in_byte <= 8'h39);
    is_dash       = (bus.in_byte == 8'h2D);
    is_lf         = (bus.in_byte == 8'h0A);
    is_cr         = (bus.in_byte == 8'h0D);
    digit_ext     = ACC_W'(bus.in_byte[3:0]);
    acc_low_next  = (acc_low_reg << 3) + (acc_low_reg << 1) + digit_ext;
    acc_high_next = (acc_high_reg << 3) + (acc_high_reg << 1) + digit_ext;
  end

  // rst gates the handshake outputs directly so they are quiet for the whole
  // reset cycle, and so in_ready rises in the very first cycle after release.
  assign in_ready_int = !rst && (state_reg != EMIT);
  assign wr_en_int    = !rst && (state_reg == EMIT) && !bus.fifo_full;
  assign consume      = bus.in_valid && in_ready_int;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= LOW;
      acc_low_reg   <= '0;
      acc_high_reg  <= '0;
      seen_low_reg  <= 1'b0;
      seen_high_reg <= 1'b0;
      low_reg       <= '0;
      high_reg      <= '0;
      count_reg     <= '0;
    end else begin
      case (state_reg)
        LOW: begin
          if (consume && !is_cr) begin
            if (is_digit) begin
              if (acc_low_next > BOUND_MAX) begin
                state_reg <= ERR;
              end else begin
                acc_low_reg  <= acc_low_next;
                seen_low_reg <= 1'b1;
              end
            end else if (is_dash) begin
              state_reg <= seen_low_reg ? HIGH : ERR;
            end else if (is_lf) begin
              state_reg <= seen_low_reg ? ERR : DONE;
            end else begin
              state_reg <= ERR;
            end
          end
        end

        HIGH: begin
          if (consume && !is_cr) begin
            if (is_digit) begin
              if (acc_high_next > BOUND_MAX) begin
                state_reg <= ERR;
              end else begin
                acc_high_reg  <= acc_high_next;
                seen_high_reg <= 1'b1;
              end
            end else if (is_lf && seen_high_reg) begin
              // Bounds are ordered and captured here, so the accumulators
              // can be cleared now and EMIT only has to hold the bounds.
              if (acc_low_reg <= acc_high_reg) begin
                low_reg  <= ADDR_W'(acc_low_reg);
                high_reg <= ADDR_W'(acc_high_reg);
              end else begin
                low_reg  <= ADDR_W'(acc_high_reg);
                high_reg <= ADDR_W'(acc_low_reg);
              end
              acc_low_reg   <= '0;
              acc_high_reg  <= '0;
              seen_low_reg  <= 1'b0;
              seen_high_reg <= 1'b0;
              state_reg     <= EMIT;
            end else begin
              state_reg <= ERR;
            end
          end
        end

        EMIT: begin
          if (!bus.fifo_full) begin
            if (count_reg != {CNT_W{1'b1}}) begin
              count_reg <= count_reg + 1'b1;
            end
            state_reg <= LOW;
          end
        end

        DONE: state_reg <= DONE;
        ERR:  state_reg <= ERR;
        default: state_reg <= ERR;
      endcase
    end
  end

  assign bus.in_ready          = in_ready_int;
  assign bus.wr_en             = wr_en_int;
  assign bus.input_range_low   = low_reg;
  assign bus.input_range_high  = high_reg;
  assign bus.input_range_fresh = wr_en_int;
  assign bus.range_count       = count_reg;
  assign bus.ranges_done       = (state_reg == DONE);
  assign bus.err               = (state_reg == ERR);

endmodule

// File: tb/tb_range_parser.sv
// ---------------------------------------------------------------------------
// tb_range_parser
// Directed scenarios for range_parser with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_range_parser;

  localparam int ADDR_W = 17;
  localparam int CNT_W  = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] lo;
    logic [ADDR_W-1:0] hi;
    logic              fr;
    int                cyc;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   viol = 0;
  wr_t  wq[$];

  range_parser_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  range_parser #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every write and any write attempted against a full FIFO.
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      wq.push_back('{lo: bus.input_range_low, hi: bus.input_range_high,
                     fr: bus.input_range_fresh, cyc: cyc});
      if (bus.fifo_full === 1'b1) viol++;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_byte_timeout: in_ready=%b required 1 (byte %h)", bus.in_ready, b);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.in_byte   = 8'h00;
    bus.fifo_full = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    wq.delete();
    viol = 0;
  endtask

  task automatic check_writes(input string name, input int n_exp);
    checks++;
    if (wq.size() !== n_exp) begin
      errors++;
      $display("FAIL %s_write_count: got %0d required %0d", name, wq.size(), n_exp);
    end
    checks++;
    if (viol !== 0) begin
      errors++;
      $display("FAIL %s_wr_while_full: got %0d required 0", name, viol);
    end
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.in_byte   = 8'h00;
    bus.fifo_full = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.in_ready, bus.wr_en, bus.input_range_fresh, bus.ranges_done, bus.err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: rdy/wr/fr/done/err=%b required 00000",
               {bus.in_ready, bus.wr_en, bus.input_range_fresh, bus.ranges_done, bus.err});
    end
    checks++;
    if (bus.range_count !== 16'd0 || bus.input_range_low !== 17'd0 || bus.input_range_high !== 17'd0) begin
      errors++;
      $display("FAIL reset_values: count=%0d low=%0d high=%0d required 0/0/0",
               bus.range_count, bus.input_range_low, bus.input_range_high);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b required 1", bus.in_ready);
    end
    $display("test_reset done");
  endtask

  task automatic test_stream();
    logic [ADDR_W-1:0] exp_lo[4] = '{17'd3, 17'd10, 17'd16, 17'd12};
    logic [ADDR_W-1:0] exp_hi[4] = '{17'd5, 17'd14, 17'd20, 17'd18};
    do_reset();
    send_str("3-5\n10-14\n16-20\n12-18\n\n");
    settle();
    check_writes("stream", 4);
    for (int i = 0; i < 4 && i < wq.size(); i++) begin
      checks++;
      if (wq[i].lo !== exp_lo[i] || wq[i].hi !== exp_hi[i] || wq[i].fr !== 1'b1) begin
        errors++;
        $display("FAIL stream_write%0d: got %0d..%0d fresh=%b required %0d..%0d fresh=1",
                 i, wq[i].lo, wq[i].hi, wq[i].fr, exp_lo[i], exp_hi[i]);
      end
    end
    checks++;
    if (bus.range_count !== 16'd4 || bus.ranges_done !== 1'b1 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL stream_status: count=%0d done=%b err=%b required 4/1/0",
               bus.range_count, bus.ranges_done, bus.err);
    end
    // Bytes after the terminating blank line are drained without writes.
    send_str("1-2\n");
    settle();
    check_writes("stream_after_done", 4);
    $display("test_stream done: %0d writes", wq.size());
  endtask

  task automatic test_backpressure();
    do_reset();
    send_str("10-14");
    bus.fifo_full = 1'b1;
    send_byte(8'h0A);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (bus.wr_en !== 1'b0 || bus.in_ready !== 1'b0 ||
          bus.input_range_low !== 17'd10 || bus.input_range_high !== 17'd14) begin
        errors++;
        $display("FAIL stall_cycle%0d: wr=%b rdy=%b low=%0d high=%0d required 0/0/10/14",
                 k, bus.wr_en, bus.in_ready, bus.input_range_low, bus.input_range_high);
      end
    end
    @(posedge clk);
    #1;
    bus.fifo_full = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.wr_en !== 1'b1 || bus.input_range_fresh !== 1'b1 ||
        bus.input_range_low !== 17'd10 || bus.input_range_high !== 17'd14) begin
      errors++;
      $display("FAIL stall_release: wr=%b fresh=%b low=%0d high=%0d required 1/1/10/14",
               bus.wr_en, bus.input_range_fresh, bus.input_range_low, bus.input_range_high);
    end
    settle();
    check_writes("stall", 1);
    checks++;
    if (bus.range_count !== 16'd1) begin
      errors++;
      $display("FAIL stall_count: got %0d required 1", bus.range_count);
    end
    $display("test_backpressure done: %0d writes", wq.size());
  endtask

  task automatic test_out_of_order();
    do_reset();
    send_str("9-4");
    send_byte(8'h0D);
    send_byte(8'h0A);
    settle();
    check_writes("swap", 1);
    if (wq.size() > 0) begin
      checks++;
      if (wq[0].lo !== 17'd4 || wq[0].hi !== 17'd9) begin
        errors++;
        $display("FAIL swap_bounds: got %0d..%0d required 4..9", wq[0].lo, wq[0].hi);
      end
    end
    checks++;
    if (bus.err !== 1'b0) begin
      errors++;
      $display("FAIL swap_err: got %b required 0", bus.err);
    end
    $display("test_out_of_order done: %0d writes", wq.size());
  endtask

  task automatic test_overflow();
    do_reset();
    send_str("131071-13107");
    checks++;
    if (bus.err !== 1'b0) begin
      errors++;
      $display("FAIL ovf_before: err=%b required 0", bus.err);
    end
    send_byte("2");
    checks++;
    if (bus.err !== 1'b1) begin
      errors++;
      $display("FAIL ovf_digit: err=%b required 1", bus.err);
    end
    send_str("5-6\n\n");
    settle();
    check_writes("ovf", 0);
    checks++;
    if (bus.err !== 1'b1 || bus.ranges_done !== 1'b0 || bus.range_count !== 16'd0) begin
      errors++;
      $display("FAIL ovf_status: err=%b done=%b count=%0d required 1/0/0",
               bus.err, bus.ranges_done, bus.range_count);
    end
    $display("test_overflow done: err=%b", bus.err);
  endtask

  task automatic test_bad_bytes();
    do_reset();
    send_str("3x");
    checks++;
    if (bus.err !== 1'b1) begin
      errors++;
      $display("FAIL bad_char: err=%b required 1", bus.err);
    end
    send_str("5\n");
    settle();
    check_writes("bad_char", 0);
    do_reset();
    send_str("-5\n");
    settle();
    check_writes("lead_dash", 0);
    checks++;
    if (bus.err !== 1'b1) begin
      errors++;
      $display("FAIL lead_dash: err=%b required 1", bus.err);
    end
    $display("test_bad_bytes done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_str("12-1");
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_str("7-8\n\n");
    settle();
    check_writes("rst_mid", 1);
    if (wq.size() > 0) begin
      checks++;
      if (wq[0].lo !== 17'd7 || wq[0].hi !== 17'd8) begin
        errors++;
        $display("FAIL rst_mid_bounds: got %0d..%0d required 7..8", wq[0].lo, wq[0].hi);
      end
    end
    checks++;
    if (bus.range_count !== 16'd1 || bus.ranges_done !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_status: count=%0d done=%b required 1/1",
               bus.range_count, bus.ranges_done);
    end
    // Reset while a range is pending in EMIT must drop it.
    do_reset();
    send_str("1-2");
    bus.fifo_full = 1'b1;
    send_byte(8'h0A);
    rst = 1'b1;
    @(posedge clk);
    #1;
    bus.fifo_full = 1'b0;
    rst = 1'b0;
    settle();
    check_writes("rst_emit", 0);
    $display("test_reset_mid done");
  endtask

  task automatic test_back_to_back();
    int lf_cyc;
    do_reset();
    send_str("3-5");
    send_byte(8'h0A);
    lf_cyc = cyc;
    send_str("1-2\n");
    settle();
    check_writes("b2b", 2);
    if (wq.size() == 2) begin
      checks++;
      if (wq[0].cyc !== lf_cyc) begin
        errors++;
        $display("FAIL b2b_latency: write cycle %0d required %0d", wq[0].cyc, lf_cyc);
      end
      checks++;
      if (wq[1].cyc - wq[0].cyc !== 5) begin
        errors++;
        $display("FAIL b2b_spacing: got %0d cycles required 5", wq[1].cyc - wq[0].cyc);
      end
      checks++;
      if (wq[1].lo !== 17'd1 || wq[1].hi !== 17'd2) begin
        errors++;
        $display("FAIL b2b_bounds: got %0d..%0d required 1..2", wq[1].lo, wq[1].hi);
      end
    end
    $display("test_back_to_back done: %0d writes", wq.size());
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_byte   = 8'h00;
    bus.fifo_full = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_out_of_order();
    test_overflow();
    test_bad_bytes();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
